vga_timing_gen: RTL

//  Parametrised VGA raster engine: H/V counters, sync generation, data-enable, pixel-clock enable divider.

---
 rtl/vga_timing_gen.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster engine: H/V counters, sync/DE generation, pixel-clock divider and
// selectable pixel source (external stream or built-in test patterns).
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned R_W      = 3,
    parameter int unsigned G_W      = 3,
    parameter int unsigned B_W      = 2,
    parameter int unsigned PIX_DIV  = 2,
    parameter int unsigned CHK_LOG2 = 5,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL),
    localparam int unsigned RGB_W   = R_W + G_W + B_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [RGB_W-1:0] solid_rgb,
    input  logic [RGB_W-1:0] ext_rgb,
    input  logic             ext_valid,
    input  logic             clr_underflow,
    output logic [HW-1:0]    req_x,
    output logic [VW-1:0]    req_y,
    output logic             req_de,
    output logic             pix_ce,
    output logic [R_W-1:0]   r,
    output logic [G_W-1:0]   g,
    output logic [B_W-1:0]   b,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame_start,
    output logic             underflow
);

    localparam int unsigned DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam logic        HS_ACT   = 1'(HS_POL);
    localparam logic        VS_ACT   = 1'(VS_POL);

    localparam logic [1:0] MODE_EXT   = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_CHK   = 2'd2;

    logic [DW-1:0]    div_q, div_d;
    logic             pix_ce_q, pix_ce_d;
    logic [HW-1:0]    x_q, x_d;
    logic [VW-1:0]    y_q, y_d;
    logic             req_de_q, req_de_d;
    logic [1:0]       mode_q, mode_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             de_q, de_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             frame_start_q, frame_start_d;
    logic             underflow_q, underflow_d;

    logic             at_origin;
    logic [1:0]       eff_mode;
    logic [2:0]       bar_idx;
    logic [RGB_W-1:0] pix_rgb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q         <= '0;
            pix_ce_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            req_de_q      <= 1'b1;
            mode_q        <= MODE_BARS;
            rgb_q         <= '0;
            de_q          <= 1'b0;
            hs_q          <= ~HS_ACT;
            vs_q          <= ~VS_ACT;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_ce_q      <= pix_ce_d;
            x_q           <= x_d;
            y_q           <= y_d;
            req_de_q      <= req_de_d;
            mode_q        <= mode_d;
            rgb_q         <= rgb_d;
            de_q          <= de_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    // Pixel strobe divider and raster counters; both parked at zero while disabled.
    always_comb begin
        div_d    = '0;
        pix_ce_d = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        if (en) begin
            div_d    = (div_q == DW'(PIX_DIV - 1)) ? '0 : div_q + DW'(1);
            pix_ce_d = (div_d == DW'(PIX_DIV - 1));
            if (pix_ce_q) begin
                if (x_q == HW'(H_TOTAL - 1)) begin
                    x_d = '0;
                    y_d = (y_q == VW'(V_TOTAL - 1)) ? '0 : y_q + VW'(1);
                end else begin
                    x_d = x_q + HW'(1);
                end
            end
        end else begin
            x_d = '0;
            y_d = '0;
        end
        req_de_d = (x_d < HW'(H_ACTIVE)) && (y_d < VW'(V_ACTIVE));
    end

    // The frame's first pixel already uses the mode being latched for that frame.
    always_comb begin
        at_origin = (x_q == '0) && (y_q == '0);
        eff_mode  = at_origin ? mode : mode_q;
        bar_idx   = 3'(x_q / HW'(BAR_W));
        pix_rgb   = '0;
        case (eff_mode)
            MODE_EXT:  pix_rgb = ext_valid ? ext_rgb : '0;
            MODE_BARS: pix_rgb = {{R_W{bar_idx[2]}}, {G_W{bar_idx[1]}}, {B_W{bar_idx[0]}}};
            MODE_CHK:  pix_rgb = {RGB_W{x_q[CHK_LOG2] ^ y_q[CHK_LOG2]}};
            default:   pix_rgb = solid_rgb;
        endcase
    end

    always_comb begin
        mode_d        = mode_q;
        rgb_d         = rgb_q;
        de_d          = de_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        frame_start_d = 1'b0;
        underflow_d   = underflow_q;
        if (clr_underflow) begin
            underflow_d = 1'b0;
        end
        if (!en) begin
            rgb_d = '0;
            de_d  = 1'b0;
            hs_d  = ~HS_ACT;
            vs_d  = ~VS_ACT;
        end else if (pix_ce_q) begin
            if (at_origin) begin
                mode_d = mode;
            end
            de_d          = req_de_q;
            rgb_d         = req_de_q ? pix_rgb : '0;
            hs_d          = ((x_q >= HW'(HS_START)) && (x_q <= HW'(HS_END))) ? HS_ACT : ~HS_ACT;
            vs_d          = ((y_q >= VW'(VS_START)) && (y_q <= VW'(VS_END))) ? VS_ACT : ~VS_ACT;
            frame_start_d = at_origin;
            if (req_de_q && (eff_mode == MODE_EXT) && !ext_valid) begin
                underflow_d = 1'b1;
            end
        end
    end

    assign req_x       = x_q;
    assign req_y       = y_q;
    assign req_de      = req_de_q;
    assign pix_ce      = pix_ce_q;
    assign r           = rgb_q[RGB_W-1 -: R_W];
    assign g           = rgb_q[B_W +: G_W];
    assign b           = rgb_q[0 +: B_W];
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign de          = de_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule
